// File: rtl/find_top_bottom.sv
// Finds the topmost bright pixel (mostTop, seed column midPix) of a small image, then
// walks down that column to find mostBottom. Optional macro MIDPOINT_REFINE_EN centres midPix on the top run.
module find_top_bottom #(
  parameter int X_RES     = 6,
  parameter int Y_RES     = 6,
  parameter int XSZ       = 3,
  parameter int YSZ       = 3,
  parameter int ADDR_SZ   = 6,
  parameter int COL_SZ    = 3,
  parameter int THRESHOLD = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [ADDR_SZ-1:0] mem_address,
  input  logic [COL_SZ-1:0]  pixVal,
  output logic [YSZ-1:0]     mostTop,
  output logic [YSZ-1:0]     mostBottom,
  output logic [XSZ-1:0]     midPix,
  output logic               TopandBottomFound,
  output logic               noStar,
  output logic               busy
);

`ifdef MIDPOINT_REFINE_EN
  typedef enum logic [3:0] {
    IDLE, ROW_RD, ROW_CHK, RUN_RD, RUN_CHK, COL_RD, COL_CHK, DONE_PULSE, DONE_HOLD, NOSTAR
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, ROW_RD, ROW_CHK, COL_RD, COL_CHK, DONE_PULSE, DONE_HOLD, NOSTAR
  } state_t;
`endif

  localparam logic [XSZ-1:0]     XMAX  = XSZ'(X_RES - 1);
  localparam logic [YSZ-1:0]     YMAX  = YSZ'(Y_RES - 1);
  localparam logic [ADDR_SZ-1:0] XRESA = ADDR_SZ'(X_RES);

  state_t         state_q;
  logic [XSZ-1:0] x_q;
  logic [YSZ-1:0] y_q;
  logic [YSZ-1:0] mostTop_q;
  logic [YSZ-1:0] mostBottom_q;
  logic [XSZ-1:0] midPix_q;
  logic           pulse_q;
  logic           noStar_q;

  logic           bright_d;
  logic [XSZ-1:0] xSel_d;

  assign bright_d = pixVal > COL_SZ'(THRESHOLD);
  // The column walk addresses the seed column rather than the row-scan x counter.
  assign xSel_d = (state_q == COL_RD || state_q == COL_CHK) ? midPix_q : x_q;
  assign mem_address = ADDR_SZ'(y_q) * XRESA + ADDR_SZ'(xSel_d);

`ifdef MIDPOINT_REFINE_EN
  logic [XSZ-1:0] runEnd_d;
  logic [XSZ-1:0] midRef_d;
  assign runEnd_d = bright_d ? x_q : x_q - XSZ'(1);
  assign midRef_d = XSZ'(({1'b0, midPix_q} + {1'b0, runEnd_d}) >> 1);
`endif

  assign mostTop           = mostTop_q;
  assign mostBottom        = mostBottom_q;
  assign midPix            = midPix_q;
  assign TopandBottomFound = pulse_q;
  assign noStar            = noStar_q;
  assign busy              = !(state_q == IDLE || state_q == DONE_HOLD || state_q == NOSTAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      mostTop_q    <= '0;
      mostBottom_q <= '0;
      midPix_q     <= '0;
      pulse_q      <= 1'b0;
      noStar_q     <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE, DONE_HOLD, NOSTAR: begin
          if (start) begin
            x_q      <= '0;
            y_q      <= '0;
            noStar_q <= 1'b0;
            state_q  <= ROW_RD;
          end
        end
        ROW_RD: state_q <= ROW_CHK;
        ROW_CHK: begin
          if (bright_d) begin
            mostTop_q <= y_q;
            midPix_q  <= x_q;
`ifdef MIDPOINT_REFINE_EN
            if (x_q != XMAX) begin
              x_q     <= x_q + XSZ'(1);
              state_q <= RUN_RD;
            end else if (y_q == YMAX) begin
              mostBottom_q <= y_q;
              state_q      <= DONE_PULSE;
            end else begin
              y_q     <= y_q + YSZ'(1);
              state_q <= COL_RD;
            end
`else
            // A shape starting on the last row has no column below it to read.
            if (y_q == YMAX) begin
              mostBottom_q <= y_q;
              state_q      <= DONE_PULSE;
            end else begin
              y_q     <= y_q + YSZ'(1);
              state_q <= COL_RD;
            end
`endif
          end else if (x_q != XMAX) begin
            x_q     <= x_q + XSZ'(1);
            state_q <= ROW_RD;
          end else if (y_q != YMAX) begin
            x_q     <= '0;
            y_q     <= y_q + YSZ'(1);
            state_q <= ROW_RD;
          end else begin
            noStar_q <= 1'b1;
            state_q  <= NOSTAR;
          end
        end
`ifdef MIDPOINT_REFINE_EN
        RUN_RD: state_q <= RUN_CHK;
        RUN_CHK: begin
          if (bright_d && x_q != XMAX) begin
            x_q     <= x_q + XSZ'(1);
            state_q <= RUN_RD;
          end else begin
            midPix_q <= midRef_d;
            if (mostTop_q == YMAX) begin
              mostBottom_q <= mostTop_q;
              state_q      <= DONE_PULSE;
            end else begin
              y_q     <= mostTop_q + YSZ'(1);
              state_q <= COL_RD;
            end
          end
        end
`endif
        COL_RD: state_q <= COL_CHK;
        COL_CHK: begin
          if (!bright_d) begin
            mostBottom_q <= y_q - YSZ'(1);
            state_q      <= DONE_PULSE;
          end else if (y_q == YMAX) begin
            mostBottom_q <= YMAX;
            state_q      <= DONE_PULSE;
          end else begin
            y_q     <= y_q + YSZ'(1);
            state_q <= COL_RD;
          end
        end
        DONE_PULSE: begin
          pulse_q <= 1'b1;
          state_q <= DONE_HOLD;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_find_top_bottom.sv
// Directed bench for find_top_bottom with a behavioural 1-cycle-latency image RAM.
// Each scenario task drives its own search and compares against hand-computed values.
module tb_find_top_bottom;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] mem_address;
  logic [2:0] pixVal;
  logic [2:0] mostTop;
  logic [2:0] mostBottom;
  logic [2:0] midPix;
  logic       TopandBottomFound;
  logic       noStar;
  logic       busy;

  logic [2:0] mem [0:63];
  int checks = 0;
  int errors = 0;
  int addrHigh = 0;

  find_top_bottom dut (
    .clk(clk), .reset(reset), .start(start), .mem_address(mem_address), .pixVal(pixVal),
    .mostTop(mostTop), .mostBottom(mostBottom), .midPix(midPix),
    .TopandBottomFound(TopandBottomFound), .noStar(noStar), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) pixVal <= mem[mem_address];

  always @(negedge clk) if (mem_address > 6'd35) addrHigh++;

  task clearImage;
    for (int i = 0; i < 64; i++) mem[i] = 3'd0;
  endtask

  task setPix(input int x, input int y, input logic [2:0] v);
    mem[y * 6 + x] = v;
  endtask

  // Edge E0 is the first rising edge that samples start; k counts edges after it.
  task runSearch(input int limit, input int startHold, output int firstPulse,
                 output int pulses, output int noStarAt);
    firstPulse = -1;
    pulses = 0;
    noStarAt = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k <= limit; k++) begin
      @(posedge clk);
      #1;
      if (TopandBottomFound) begin
        pulses++;
        if (firstPulse < 0) firstPulse = k;
      end
      if (noStar && noStarAt < 0) noStarAt = k;
      if (k + 1 >= startHold) start = 1'b0;
    end
  endtask

  task test_reset;
    reset = 1'b1;
    start = 1'b0;
    clearImage();
    #12;
    checks++; if (mostTop !== 3'd0) begin errors++; $display("[TB] FAIL rst_mostTop got %0d want 0", mostTop); end
    checks++; if (mostBottom !== 3'd0) begin errors++; $display("[TB] FAIL rst_mostBottom got %0d want 0", mostBottom); end
    checks++; if (midPix !== 3'd0) begin errors++; $display("[TB] FAIL rst_midPix got %0d want 0", midPix); end
    checks++; if ({TopandBottomFound, noStar, busy} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags got %b want 000", {TopandBottomFound, noStar, busy}); end
    checks++; if (mem_address !== 6'd0) begin errors++; $display("[TB] FAIL rst_addr got %0d want 0", mem_address); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task test_bar;
    int fp, np, ns;
    clearImage();
    for (int y = 1; y <= 3; y++) setPix(2, y, 3'd5);
    runSearch(40, 1, fp, np, ns);
    checks++; if (fp !== 25) begin errors++; $display("[TB] FAIL bar_pulse_edge got %0d want 25", fp); end
    checks++; if (np !== 1) begin errors++; $display("[TB] FAIL bar_pulse_count got %0d want 1", np); end
    checks++; if (mostTop !== 3'd1) begin errors++; $display("[TB] FAIL bar_mostTop got %0d want 1", mostTop); end
    checks++; if (mostBottom !== 3'd3) begin errors++; $display("[TB] FAIL bar_mostBottom got %0d want 3", mostBottom); end
    checks++; if (midPix !== 3'd2) begin errors++; $display("[TB] FAIL bar_midPix got %0d want 2", midPix); end
    checks++; if ({noStar, busy} !== 2'b00) begin errors++; $display("[TB] FAIL bar_noStar_busy got %b want 00", {noStar, busy}); end
  endtask

  task test_all_dark;
    int fp, np, ns;
    clearImage();
    runSearch(80, 1, fp, np, ns);
    checks++; if (ns !== 72) begin errors++; $display("[TB] FAIL dark_noStar_edge got %0d want 72", ns); end
    checks++; if (np !== 0) begin errors++; $display("[TB] FAIL dark_pulses got %0d want 0", np); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if ({noStar, busy} !== 2'b10) begin errors++; $display("[TB] FAIL dark_hold got %b want 10", {noStar, busy}); end
    checks++; if ({mostTop, midPix} !== {3'd1, 3'd2}) begin errors++; $display("[TB] FAIL dark_keep_old got %0d/%0d want 1/2", mostTop, midPix); end
  endtask

  task test_corner_pixel;
    int fp, np, ns;
    clearImage();
    setPix(5, 5, 3'd1);
    addrHigh = 0;
    runSearch(90, 1, fp, np, ns);
    checks++; if (fp !== 73) begin errors++; $display("[TB] FAIL corner_pulse_edge got %0d want 73", fp); end
    checks++; if (np !== 1) begin errors++; $display("[TB] FAIL corner_pulse_count got %0d want 1", np); end
    checks++; if ({mostTop, mostBottom, midPix} !== {3'd5, 3'd5, 3'd5}) begin errors++; $display("[TB] FAIL corner_coords got %0d/%0d/%0d want 5/5/5", mostTop, mostBottom, midPix); end
    checks++; if (noStar !== 1'b0) begin errors++; $display("[TB] FAIL corner_noStar_clear got %b want 0", noStar); end
    checks++; if (addrHigh !== 0) begin errors++; $display("[TB] FAIL corner_addr_range got %0d want 0 over-range cycles", addrHigh); end
  endtask

  task test_bottom_edge;
    int fp, np, ns;
    clearImage();
    for (int y = 2; y <= 5; y++) setPix(0, y, 3'd2);
    runSearch(45, 1, fp, np, ns);
    checks++; if (fp !== 33) begin errors++; $display("[TB] FAIL bottom_pulse_edge got %0d want 33", fp); end
    checks++; if ({mostTop, mostBottom, midPix} !== {3'd2, 3'd5, 3'd0}) begin errors++; $display("[TB] FAIL bottom_coords got %0d/%0d/%0d want 2/5/0", mostTop, mostBottom, midPix); end
  endtask

  task test_reset_midscan;
    int fp, np, ns, seen;
    clearImage();
    for (int y = 0; y <= 4; y++) setPix(3, y, 3'd4);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    checks++; if ({busy, midPix} !== {1'b1, 3'd3}) begin errors++; $display("[TB] FAIL midscan_pre got %b/%0d want 1/3", busy, midPix); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({mostTop, mostBottom, midPix} !== 9'd0) begin errors++; $display("[TB] FAIL midscan_async_coords got %0d/%0d/%0d want 0/0/0", mostTop, mostBottom, midPix); end
    checks++; if ({TopandBottomFound, noStar, busy} !== 3'b000) begin errors++; $display("[TB] FAIL midscan_async_flags got %b want 000", {TopandBottomFound, noStar, busy}); end
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) reset = 1'b0;
      if (TopandBottomFound) seen++;
    end
    checks++; if ({seen, busy} !== {32'd0, 1'b0}) begin errors++; $display("[TB] FAIL midscan_no_pulse got %0d/%b want 0/0", seen, busy); end
    runSearch(30, 12, fp, np, ns);
    checks++; if (fp !== 19) begin errors++; $display("[TB] FAIL restart_pulse_edge got %0d want 19", fp); end
    checks++; if (np !== 1) begin errors++; $display("[TB] FAIL restart_pulse_count got %0d want 1", np); end
    checks++; if ({mostTop, mostBottom, midPix} !== {3'd0, 3'd4, 3'd3}) begin errors++; $display("[TB] FAIL restart_coords got %0d/%0d/%0d want 0/4/3", mostTop, mostBottom, midPix); end
  endtask

  task test_midpoint;
    int fp, np, ns;
    clearImage();
    for (int x = 1; x <= 4; x++) setPix(x, 1, 3'd7);
    setPix(2, 2, 3'd7);
    runSearch(40, 1, fp, np, ns);
`ifdef MIDPOINT_REFINE_EN
    checks++; if (fp !== 29) begin errors++; $display("[TB] FAIL mid_pulse_edge got %0d want 29", fp); end
    checks++; if ({mostTop, mostBottom, midPix} !== {3'd1, 3'd2, 3'd2}) begin errors++; $display("[TB] FAIL mid_coords got %0d/%0d/%0d want 1/2/2", mostTop, mostBottom, midPix); end
`else
    checks++; if (fp !== 19) begin errors++; $display("[TB] FAIL mid_pulse_edge got %0d want 19", fp); end
    checks++; if ({mostTop, mostBottom, midPix} !== {3'd1, 3'd1, 3'd1}) begin errors++; $display("[TB] FAIL mid_coords got %0d/%0d/%0d want 1/1/1", mostTop, mostBottom, midPix); end
`endif
    checks++; if (np !== 1) begin errors++; $display("[TB] FAIL mid_pulse_count got %0d want 1", np); end
  endtask

  initial begin
    $display("[TB] find_top_bottom directed tests");
    test_reset();
    test_bar();
    test_all_dark();
    test_corner_pixel();
    test_bottom_edge();
    test_reset_midscan();
    test_midpoint();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
